scan_decoder: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with an enable, a direct-select mode and an auto-scan mode. In direct mode it decodes a select value accepted over a valid/ready handshake. In scan mode an internal prescaled counter walks the active output across indices 0..SCAN_LAST and wraps. It drives digit/row selects for multiplexed displays and keypads, and generalises the fixed 4-to-16 combinational decoder.

---
 rtl/scan_decoder.sv | 105 ++++++++++
 tb/tb_scan_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// ============================================================================
//  Module   : scan_decoder
//  Purpose  : Registered one-hot select decoder with direct (handshake) and
//             prescaled auto-scan modes, for display digit / keypad row drive.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_decoder #(
  parameter int SEL_W     = 4,
  parameter int TICK_DIV  = 4,
  parameter int SCAN_LAST = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    in_ready,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] SCAN_LAST_C = SEL_W'(SCAN_LAST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [SEL_W-1:0]     cur_q, cur_d;
  logic [OUT_W-1:0]     dout_q, dout_d;
  logic                 wrap_q, wrap_d;

  assign in_ready = en & ~mode & ~rst;
  assign dout     = dout_q;
  assign cur_sel  = cur_q;
  assign wrap     = wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cur_q   <= '0;
      dout_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cur_q   <= cur_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cur_d   = cur_q;
    wrap_d  = 1'b0;
    dout_d  = '0;

    // With en low everything freezes; only the blanking of dout happens.
    if (en) begin
      if (!mode) begin
        // Leaving scan on a terminal count takes priority: no advance, no wrap.
        if (state_q == S_SCAN) begin
          state_d = S_DIRECT;
        end
        if (in_valid) begin
          state_d = S_DIRECT;
          cur_d   = in_sel;
        end
      end else if (state_q != S_SCAN) begin
        state_d = S_SCAN;
        pre_d   = '0;
      end else if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (cur_q >= SCAN_LAST_C) begin
          cur_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cur_d = cur_q + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end

      if (state_d != S_IDLE) begin
        dout_d[cur_d] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_decoder.sv
// ============================================================================
//  Module   : tb_scan_decoder
//  Purpose  : Directed self-checking bench for scan_decoder (default build and
//             a TICK_DIV=1 / SCAN_LAST=3 build).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, mode, in_valid;
  logic [3:0]  in_sel;
  logic        in_ready;
  logic [15:0] dout;
  logic [3:0]  cur_sel;
  logic        wrap;

  logic        en3, mode3, valid3;
  logic [3:0]  sel3;
  logic        ready3;
  logic [15:0] dout3;
  logic [3:0]  cur3;
  logic        wrap3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scan_decoder u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_ready (in_ready),
    .dout     (dout),
    .cur_sel  (cur_sel),
    .wrap     (wrap)
  );

  scan_decoder #(.SEL_W(4), .TICK_DIV(1), .SCAN_LAST(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .en       (en3),
    .mode     (mode3),
    .in_valid (valid3),
    .in_sel   (sel3),
    .in_ready (ready3),
    .dout     (dout3),
    .cur_sel  (cur3),
    .wrap     (wrap3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = 4'd0;
    en3 = 1'b0; mode3 = 1'b0; valid3 = 1'b0; sel3 = 4'd0;

    // 1: reset, then direct load of 9
    step(); step();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_cur", 32'(cur_sel), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 4'd9;
    #1;
    chk("direct_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("direct_cur", 32'(cur_sel), 32'd9);
    chk("direct_dout", 32'(dout), 32'h0200);

    // Idle after reset keeps outputs blank
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("idle_dout", 32'(dout), 32'h0);

    // 2: full default scan from 0, 4 cycles per step
    mode = 1'b1;
    step();
    chk("scan_entry_dout", 32'(dout), 32'h0001);
    step(); step(); step();
    chk("scan_hold_cur", 32'(cur_sel), 32'd0);
    step();
    chk("scan_step1_cur", 32'(cur_sel), 32'd1);
    chk("scan_step1_dout", 32'(dout), 32'h0002);
    for (int k = 2; k <= 15; k++) begin
      repeat (4) step();
      chk("scan_walk_cur", 32'(cur_sel), 32'(k));
      chk("scan_walk_dout", 32'(dout), 32'h1 << k);
    end
    repeat (3) step();
    chk("prewrap_cur", 32'(cur_sel), 32'd15);
    chk("prewrap_wrap", 32'(wrap), 32'h0);
    step();
    chk("wrap_cur", 32'(cur_sel), 32'd0);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    chk("wrap_dout", 32'(dout), 32'h0001);
    step();
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // 4: freeze at 5 with the prescaler mid-phase, then resume
    repeat (19) step();
    chk("at5_cur", 32'(cur_sel), 32'd5);
    step();
    en = 1'b0;
    step();
    chk("en0_dout", 32'(dout), 32'h0);
    chk("en0_cur", 32'(cur_sel), 32'd5);
    repeat (9) step();
    chk("en0_hold_cur", 32'(cur_sel), 32'd5);
    chk("en0_wrap", 32'(wrap), 32'h0);
    en = 1'b1;
    step();
    chk("resume_dout", 32'(dout), 32'h0020);
    step();
    chk("resume_phase_hold", 32'(cur_sel), 32'd5);
    step();
    chk("resume_phase_adv", 32'(cur_sel), 32'd6);

    // 5: in_valid ignored in scan; mode->0 on terminal count wins
    in_valid = 1'b1; in_sel = 4'd3;
    #1;
    chk("scan_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("scan_ignore_valid", 32'(cur_sel), 32'd6);
    step(); step();
    mode = 1'b0; in_valid = 1'b0;
    step();
    chk("modechg_cur", 32'(cur_sel), 32'd6);
    chk("modechg_wrap", 32'(wrap), 32'h0);
    chk("modechg_dout", 32'(dout), 32'h0040);

    // 6: reset mid-scan at 11
    mode = 1'b1;
    step();
    repeat (20) step();
    chk("at11_cur", 32'(cur_sel), 32'd11);
    rst = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 4'd7;
    #1;
    chk("rst_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("midrst_dout", 32'(dout), 32'h0);
    chk("midrst_cur", 32'(cur_sel), 32'h0);
    chk("midrst_wrap", 32'(wrap), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk("postrst_idle_dout", 32'(dout), 32'h0);

    // 3: SCAN_LAST=3, TICK_DIV=1 build
    rst = 1'b1; step(); rst = 1'b0;
    en3 = 1'b1; mode3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("s3_dout", 32'(dout3), 32'h1 << (i % 4));
      chk("s3_wrap", 32'(wrap3), ((i % 4) == 0 && i > 0) ? 32'h1 : 32'h0);
    end
    mode3 = 1'b0; valid3 = 1'b1; sel3 = 4'd12;
    step();
    chk("s3_load_cur", 32'(cur3), 32'd12);
    chk("s3_load_dout", 32'(dout3), 32'h1000);
    valid3 = 1'b0; mode3 = 1'b1;
    step();
    chk("s3_entry_cur", 32'(cur3), 32'd12);
    step();
    chk("s3_over_cur", 32'(cur3), 32'd0);
    chk("s3_over_wrap", 32'(wrap3), 32'h1);
    chk("s3_over_dout", 32'(dout3), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
